// File: rtl/write_module.sv
// Vector write-back: snapshots a vector (or scalar) on start and streams it to memory, one element per clock.
// Latency: element 0 is presented the cycle after the start edge; done pulses one cycle after the last element.
// Backpressure: none; start is ignored while busy. Optional address stride via WRITE_MODULE_STRIDE_EN.
module write_module #(
    parameter int N      = 20,
    parameter int DATA_W = 10,
    parameter int ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   scalar_mode,
    input  logic [ADDR_W-1:0]      base_address,
`ifdef WRITE_MODULE_STRIDE_EN
    input  logic [ADDR_W-1:0]      stride,
`endif
    input  logic [N:0][DATA_W-1:0] vector_data,
    output logic [ADDR_W-1:0]      write_address,
    output logic [DATA_W-1:0]      write_data,
    output logic                   write_enable,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = (N < 1) ? 1 : $clog2(N + 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        last;
    logic [IDX_W-1:0]        next_idx;
    logic [N:0][DATA_W-1:0]  snap_vec;
    logic [ADDR_W-1:0]       step;

`ifdef WRITE_MODULE_STRIDE_EN
    logic [ADDR_W-1:0]       snap_stride;
    assign step = snap_stride;
`else
    assign step = ADDR_W'(1);
`endif

    assign next_idx = idx + IDX_W'(1);

    // write_address doubles as the running base + idx*step accumulator; it wraps at ADDR_W bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            idx           <= '0;
            last          <= '0;
            snap_vec      <= '0;
            write_address <= '0;
            write_data    <= '0;
            write_enable  <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef WRITE_MODULE_STRIDE_EN
            snap_stride   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    write_enable <= 1'b0;
                    if (start) begin
                        snap_vec      <= vector_data;
                        last          <= scalar_mode ? '0 : IDX_W'(N);
                        idx           <= '0;
                        write_address <= base_address;
                        write_data    <= vector_data[0];
                        write_enable  <= 1'b1;
                        busy          <= 1'b1;
                        state         <= WRITE;
`ifdef WRITE_MODULE_STRIDE_EN
                        snap_stride   <= stride;
`endif
                    end
                end
                WRITE: begin
                    if (idx == last) begin
                        state        <= IDLE;
                        idx          <= '0;
                        write_enable <= 1'b0;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                    end else begin
                        idx           <= next_idx;
                        write_address <= write_address + step;
                        write_data    <= snap_vec[next_idx];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_module.sv
// Scoreboard bench for write_module: expected writes are queued at start and popped on each write strobe.
module tb_write_module;

    localparam int N  = 20;
    localparam int DW = 10;
    localparam int AW = 6;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               scalar_mode;
    logic [AW-1:0]      base_address;
    logic [AW-1:0]      stride_v;
    logic [N:0][DW-1:0] vector_data;
    logic [AW-1:0]      write_address;
    logic [DW-1:0]      write_data;
    logic               write_enable;
    logic               busy;
    logic               done;

    always #5 clk = ~clk;

    write_module #(.N(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .scalar_mode  (scalar_mode),
        .base_address (base_address),
`ifdef WRITE_MODULE_STRIDE_EN
        .stride       (stride_v),
`endif
        .vector_data  (vector_data),
        .write_address(write_address),
        .write_data   (write_data),
        .write_enable (write_enable),
        .busy         (busy),
        .done         (done)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    always @(negedge clk) begin : monitor
        wr_t e;
        if (rst === 1'b1 && write_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(write_address), 32'(e.addr));
                check("wr_data", 32'(write_data), 32'(e.data));
            end
        end
    end

    // One operation; disturb changes inputs after start and re-pulses start at element 3,
    // reset_at > 0 asserts reset mid-operation while element reset_at-1 is on the bus.
    task automatic run_op(input logic [AW-1:0] base, input logic scal, input logic [AW-1:0] strd,
                          input logic [DW-1:0] dbase, input int reset_at, input bit disturb);
        int  last;
        int  busy_cnt;
        int  done_cnt;
        int  done_k;
        wr_t w;
        last     = scal ? 0 : N;
        busy_cnt = 0;
        done_cnt = 0;
        done_k   = -1;
        @(negedge clk);
        for (int i = 0; i <= N; i++) vector_data[i] = dbase + DW'(i);
        base_address = base;
        scalar_mode  = scal;
        stride_v     = strd;
        for (int i = 0; i <= last; i++) begin
            w.addr = AW'(int'(base) + i * int'(strd));
            w.data = dbase + DW'(i);
            exp_q.push_back(w);
        end
        start = 1'b1;
        for (int k = 1; k <= last + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                if (disturb) begin
                    vector_data  = '1;
                    base_address = ~base;
                    scalar_mode  = ~scal;
                    stride_v     = ~strd;
                end
            end
            if (disturb && k == 4) start = 1'b1;
            if (disturb && k == 5) start = 1'b0;
            if (k == reset_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_we", 32'(write_enable), 32'd0);
                check("rst_busy", 32'(busy), 32'd0);
                check("rst_done", 32'(done), 32'd0);
                check("rst_addr", 32'(write_address), 32'd0);
                check("rst_data", 32'(write_data), 32'd0);
                exp_q.delete();
                repeat (2) @(negedge clk);
                rst = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    @(negedge clk);
                    check("no_done_after_rst", 32'(done), 32'd0);
                    check("no_busy_after_rst", 32'(busy), 32'd0);
                end
                return;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
        end
        check("done_latency", 32'(done_k), 32'(last + 2));
        check("busy_cycles", 32'(busy_cnt), 32'(last + 1));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'($urandom);
        scalar_mode  = 1'($urandom);
        base_address = AW'($urandom);
        stride_v     = 6'd1;
        for (int i = 0; i <= N; i++) vector_data[i] = DW'($urandom);
        #12;
        check("reset_we", 32'(write_enable), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_addr", 32'(write_address), 32'd0);
        check("reset_data", 32'(write_data), 32'd0);
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("idle_we", 32'(write_enable), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(done), 32'd0);
        end

        run_op(6'd34, 1'b0, 6'd1, 10'd900, 0, 1'b0);
        run_op(6'd10, 1'b1, 6'd1, 10'd5,   0, 1'b0);
        run_op(6'd60, 1'b0, 6'd1, 10'd900, 0, 1'b0);
`ifdef WRITE_MODULE_STRIDE_EN
        run_op(6'd0,  1'b0, 6'd2, 10'd900, 0, 1'b0);
        run_op(6'd7,  1'b0, 6'd0, 10'd900, 0, 1'b0);
`endif
        run_op(6'd34, 1'b0, 6'd1, 10'd900, 0, 1'b1);
        run_op(6'd34, 1'b0, 6'd1, 10'd900, 6, 1'b0);
        run_op(6'd34, 1'b0, 6'd1, 10'd900, 0, 1'b0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
